// File: rtl/key_mode_ctrl.sv
// Purpose : 4-key debounced mode selector driving four timed LED patterns.
// Latency : key stable high at edge 0 -> mode/led/mode_chg update at edge DEBOUNCE_CYC+3.
// Backpr. : none; every press is acted on, simultaneous presses resolve to the lowest key.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   key[3:0]  raw asynchronous keys, 1 = pressed
//   led[3:0]  LED drive, 1 = lit (registered)
//   mode[2:0] 0 IDLE, 1 FLOW_L, 2 FLOW_R, 3 BLINK, 4 RUN (registered)
//   mode_chg  one-cycle pulse in the cycle the new mode first appears
module key_mode_ctrl #(
    parameter int STEP_CYC     = 25_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [3:0] led,
    output logic [2:0] mode,
    output logic       mode_chg
);

    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int SW = $clog2(STEP_CYC);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLOW_L = 3'd1,
        FLOW_R = 3'd2,
        BLINK  = 3'd3,
        RUN    = 3'd4
    } mode_e;

    // ---------------- key input path ----------------
    logic [3:0]    sync1, sync2;
    logic [3:0]    deb, deb_d;
    logic [3:0]    press;
    logic [DW-1:0] db_cnt [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            press <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            deb_d <= deb;
            // Registered rising edge of the debounced level; releases are ignored.
            press <= deb & ~deb_d;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ---------------- mode FSM and pattern stepper ----------------
    mode_e         mode_q, mode_nx;
    logic [3:0]    led_q, led_nx;
    logic [SW-1:0] step_cnt, cnt_nx;
    logic          dir_q, dir_nx;   // RUN direction, 1 = moving towards led[3]
    logic          chg_q, chg_nx;
    mode_e         target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= IDLE;
            led_q    <= '0;
            step_cnt <= '0;
            dir_q    <= 1'b1;
            chg_q    <= 1'b0;
        end else begin
            mode_q   <= mode_nx;
            led_q    <= led_nx;
            step_cnt <= cnt_nx;
            dir_q    <= dir_nx;
            chg_q    <= chg_nx;
        end
    end

    always_comb begin
        mode_nx = mode_q;
        led_nx  = led_q;
        cnt_nx  = step_cnt;
        dir_nx  = dir_q;
        chg_nx  = 1'b0;
        target  = IDLE;

        // Lowest key index wins among simultaneous presses.
        if      (press[0]) target = FLOW_L;
        else if (press[1]) target = FLOW_R;
        else if (press[2]) target = BLINK;
        else if (press[3]) target = RUN;

        if (|press) begin
            // A press beats a step that falls on the same edge.
            mode_nx = (target == mode_q) ? IDLE : target;
            chg_nx  = 1'b1;
            cnt_nx  = '0;
            dir_nx  = 1'b1;
            case (mode_nx)
                FLOW_L:  led_nx = 4'b1000;
                FLOW_R:  led_nx = 4'b0001;
                BLINK:   led_nx = 4'b1111;
                RUN:     led_nx = 4'b0001;
                default: led_nx = 4'b0000;
            endcase
        end else if (mode_q == IDLE) begin
            cnt_nx = '0;
            led_nx = 4'b0000;
        end else if (step_cnt == SW'(STEP_CYC - 1)) begin
            cnt_nx = '0;
            case (mode_q)
                FLOW_L: led_nx = {led_q[0], led_q[3:1]};
                FLOW_R: led_nx = {led_q[2:0], led_q[3]};
                BLINK:  led_nx = ~led_q;
                RUN: begin
                    // Flip direction on the step that lands on an end LED,
                    // so each end is lit for exactly one step.
                    if (dir_q) begin
                        led_nx = {led_q[2:0], 1'b0};
                        if (led_q[2]) dir_nx = 1'b0;
                    end else begin
                        led_nx = {1'b0, led_q[3:1]};
                        if (led_q[1]) dir_nx = 1'b1;
                    end
                end
                default: led_nx = 4'b0000;
            endcase
        end else begin
            cnt_nx = step_cnt + 1'b1;
        end
    end

    assign led      = led_q;
    assign mode     = mode_q;
    assign mode_chg = chg_q;

endmodule
